// File: rtl/jt51_slot_pkg.sv
// Shared sizing helpers for the slot-multiplexed register store.
// Queue entry layout, MSB to LSB: {slot, data, mask}.
package jt51_slot_pkg;

  function automatic int unsigned slot_w(input int unsigned ch_w, input int unsigned op_w);
    return ch_w + op_w;
  endfunction

  function automatic int unsigned num_slots(input int unsigned ch_w, input int unsigned op_w);
    return 1 << (ch_w + op_w);
  endfunction

  function automatic int unsigned entry_w(input int unsigned ch_w, input int unsigned op_w,
                                          input int unsigned dw);
    return ch_w + op_w + 2 * dw;
  endfunction

  // Bit offsets of the data and slot fields inside a queue entry
  function automatic int unsigned data_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned slot_lsb(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic bit stg_ok(input int unsigned stg, input int unsigned ch_w,
                                input int unsigned op_w);
    return stg < num_slots(ch_w, op_w);
  endfunction

endpackage

// File: rtl/jt51_slot_fifo.sv
// Small synchronous FIFO holding pending slot writes; async active-low clear.
module jt51_slot_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer separates full from empty
  logic [AW:0]      wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    dout    = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= din;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jt51_slot_csr.sv
// Slot-multiplexed operator/channel field store with queued, slot-aligned writes,
// a stage-offset slot output and a registered CPU read-back port.
module jt51_slot_csr
  import jt51_slot_pkg::*;
#(
  parameter int unsigned CH_W   = 3,
  parameter int unsigned OP_W   = 2,
  parameter int unsigned DW     = 8,
  parameter int unsigned STG    = 1,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [OP_W-1:0]      wr_op,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [DW-1:0]        wr_data,
  input  logic [DW-1:0]        wr_mask,
  input  logic [OP_W-1:0]      rd_op,
  input  logic [CH_W-1:0]      rd_ch,
  output logic [DW-1:0]        rd_data,
  output logic [OP_W+CH_W-1:0] slot,
  output logic                 zero,
  output logic                 half,
  output logic [DW-1:0]        dout,
  output logic                 pending
);

  localparam int unsigned SW = slot_w(CH_W, OP_W);
  localparam int unsigned N  = num_slots(CH_W, OP_W);
  localparam int unsigned EW = entry_w(CH_W, OP_W, DW);
  localparam int unsigned DL = data_lsb(DW);
  localparam int unsigned SL = slot_lsb(DW);
  localparam logic [SW-1:0] StgOff = SW'(STG);

  if (!stg_ok(STG, CH_W, OP_W)) begin : g_stg_range
    $error("jt51_slot_csr: STG must be below the slot count");
  end

  logic [DW-1:0] field_q [N];
  logic [SW-1:0] slot_q, slot_d, rd_idx;
  logic          zero_q, half_q;
  logic [DW-1:0] dout_q, dout_d, rd_q, merged;

  logic [EW-1:0] q_din, q_dout;
  logic          q_full, q_empty, q_push, q_pop;
  logic [SW-1:0] head_slot;
  logic [DW-1:0] head_data, head_mask;
  logic          commit;

  jt51_slot_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    q_din     = {wr_op, wr_ch, wr_data, wr_mask};
    q_push    = wr_valid && !q_full;
    head_slot = q_dout[SL +: SW];
    head_data = q_dout[DL +: DW];
    head_mask = q_dout[DW-1:0];
    // Head may only commit while the counter sits on its slot
    commit    = cen && !q_empty && (head_slot == slot_q);
    q_pop     = commit;
    merged    = (field_q[slot_q] & ~head_mask) | (head_data & head_mask);
    slot_d    = slot_q + SW'(1);
    rd_idx    = slot_q - StgOff;
    // Write-through so STG=0 shows the committed value on the commit edge
    dout_d    = (commit && (rd_idx == slot_q)) ? merged : field_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      zero_q <= 1'b0;
      half_q <= 1'b0;
      dout_q <= '0;
      rd_q   <= '0;
      for (int i = 0; i < int'(N); i++) begin
        field_q[i] <= '0;
      end
    end else begin
      if (commit) begin
        field_q[slot_q] <= merged;
      end
      if (cen) begin
        slot_q <= slot_d;
        zero_q <= (slot_d == '0);
        half_q <= (slot_d[SW-2:0] == '0);
        dout_q <= dout_d;
      end
      rd_q <= field_q[{rd_op, rd_ch}];
    end
  end

  always_comb begin
    wr_ready = !q_full;
    pending  = !q_empty;
    slot     = slot_q;
    zero     = zero_q;
    half     = half_q;
    dout     = dout_q;
    rd_data  = rd_q;
  end

endmodule

// File: tb/tb_jt51_slot_csr.sv
// Directed bench for jt51_slot_csr at default parameters (32 slots, STG=1, 4-deep queue).
module tb_jt51_slot_csr;

  logic       clk = 1'b0;
  logic       rst_n, cen, wr_valid, wr_ready;
  logic [1:0] wr_op, rd_op;
  logic [2:0] wr_ch, rd_ch;
  logic [7:0] wr_data, wr_mask, rd_data, dout;
  logic [4:0] slot;
  logic       zero, half, pending;

  int n_cmp = 0;
  int n_err = 0;

  jt51_slot_csr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_op    (wr_op),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .rd_op    (rd_op),
    .rd_ch    (rd_ch),
    .rd_data  (rd_data),
    .slot     (slot),
    .zero     (zero),
    .half     (half),
    .dout     (dout),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_slot(input logic [4:0] s);
    for (int i = 0; i < 200 && slot != s; i++) tick();
    check_eq("goto_slot", 32'(slot), 32'(s));
  endtask

  task automatic push(input logic [1:0] op, input logic [2:0] ch,
                      input logic [7:0] data, input logic [7:0] mask);
    bit done = 0;
    wr_valid = 1'b1;
    wr_op    = op;
    wr_ch    = ch;
    wr_data  = data;
    wr_mask  = mask;
    for (int i = 0; i < 200 && !done; i++) begin
      if (wr_ready) done = 1;
      tick();
    end
    wr_valid = 1'b0;
    if (!done) check_eq("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && pending; i++) tick();
    check_eq("drain", 32'(pending), 32'(0));
  endtask

  logic [7:0] fifo_exp [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cen = 1'b1; wr_valid = 1'b0;
    wr_op = '0; wr_ch = '0; wr_data = '0; wr_mask = '0;
    rd_op = '0; rd_ch = '0;
    tick(); tick();
    check_eq("rst_slot", 32'(slot), 32'(0));
    check_eq("rst_zero", 32'(zero), 32'(0));
    check_eq("rst_half", 32'(half), 32'(0));
    check_eq("rst_dout", 32'(dout), 32'(0));
    check_eq("rst_ready", 32'(wr_ready), 32'(1));
    check_eq("rst_pending", 32'(pending), 32'(0));
    rst_n = 1'b1;

    // Basic write: op2 ch5 -> slot 21, issued at slot 3
    rd_op = 2'd2; rd_ch = 3'd5;
    goto_slot(5'd3);
    push(2'd2, 3'd5, 8'hA5, 8'hFF);
    check_eq("a_pending", 32'(pending), 32'(1));
    goto_slot(5'd21);
    check_eq("a_not_visible", 32'(rd_data), 32'(0));
    check_eq("a_pending21", 32'(pending), 32'(1));
    tick();
    check_eq("a_popped", 32'(pending), 32'(0));
    check_eq("a_dout22", 32'(dout), 32'(0));
    tick();
    check_eq("a_slot23", 32'(slot), 32'(23));
    check_eq("a_dout23", 32'(dout), 32'hA5);
    check_eq("a_rd", 32'(rd_data), 32'hA5);

    // Wrap, zero/half, write to slot 0 issued at slot 31
    goto_slot(5'd31);
    check_eq("w_zero31", 32'(zero), 32'(0));
    check_eq("w_half31", 32'(half), 32'(0));
    tick();
    check_eq("w_zero0", 32'(zero), 32'(1));
    check_eq("w_half0", 32'(half), 32'(1));
    tick();
    check_eq("w_zero1", 32'(zero), 32'(0));
    check_eq("w_half1", 32'(half), 32'(0));
    goto_slot(5'd16);
    check_eq("w_half16", 32'(half), 32'(1));
    check_eq("w_zero16", 32'(zero), 32'(0));
    rd_op = 2'd0; rd_ch = 3'd0;
    goto_slot(5'd31);
    push(2'd0, 3'd0, 8'h5A, 8'hFF);
    check_eq("w_slot0", 32'(slot), 32'(0));
    check_eq("w_pend0", 32'(pending), 32'(1));
    tick();
    check_eq("w_commit0", 32'(pending), 32'(0));
    tick();
    check_eq("w_dout2", 32'(dout), 32'h5A);
    check_eq("w_rd0", 32'(rd_data), 32'h5A);

    // Masked merge on slot 1: F0 then data 0F mask 3C -> CC
    push(2'd0, 3'd1, 8'hF0, 8'hFF);
    push(2'd0, 3'd1, 8'h0F, 8'h3C);
    wait_idle();
    rd_op = 2'd0; rd_ch = 3'd1;
    tick();
    check_eq("m_merge", 32'(rd_data), 32'hCC);

    // Full queue, all targeting slot 31
    fifo_exp[0] = 8'h11; fifo_exp[1] = 8'h22; fifo_exp[2] = 8'h33;
    fifo_exp[3] = 8'h44; fifo_exp[4] = 8'h55;
    goto_slot(5'd0);
    for (int k = 0; k < 4; k++) push(2'd3, 3'd7, fifo_exp[k], 8'hFF);
    check_eq("f_ready_full", 32'(wr_ready), 32'(0));
    check_eq("f_slot4", 32'(slot), 32'(4));
    push(2'd3, 3'd7, fifo_exp[4], 8'hFF);
    check_eq("f_accept_slot", 32'(slot), 32'(1));
    check_eq("f_dout0", 32'(dout), 32'(fifo_exp[0]));
    for (int k = 1; k < 5; k++) begin
      tick();
      goto_slot(5'd1);
      check_eq("f_order", 32'(dout), 32'(fifo_exp[k]));
    end
    check_eq("f_drained", 32'(pending), 32'(0));

    // cen gating around slot 10 (op1 ch2)
    goto_slot(5'd10);
    cen = 1'b0;
    rd_op = 2'd1; rd_ch = 3'd2;
    push(2'd1, 3'd2, 8'h77, 8'hFF);
    push(2'd1, 3'd2, 8'h88, 8'hFF);
    push(2'd1, 3'd2, 8'h99, 8'hFF);
    check_eq("c_frozen", 32'(slot), 32'(10));
    tick();
    check_eq("c_no_commit", 32'(pending), 32'(1));
    check_eq("c_rd_old", 32'(rd_data), 32'(0));
    for (int i = 0; i < 9; i++) begin
      cen = (i % 3 == 0);
      tick();
      if (i == 2) check_eq("c_slot_hold", 32'(slot), 32'(11));
    end
    cen = 1'b1;
    check_eq("c_slot13", 32'(slot), 32'(13));
    check_eq("c_rd77", 32'(rd_data), 32'h77);
    check_eq("c_pending", 32'(pending), 32'(1));

    // Reset with three writes queued
    push(2'd1, 3'd2, 8'hAA, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("r_slot", 32'(slot), 32'(0));
    check_eq("r_rd", 32'(rd_data), 32'(0));
    check_eq("r_dout", 32'(dout), 32'(0));
    check_eq("r_zero", 32'(zero), 32'(0));
    check_eq("r_half", 32'(half), 32'(0));
    check_eq("r_ready", 32'(wr_ready), 32'(1));
    check_eq("r_pending", 32'(pending), 32'(0));
    tick(); tick();
    rst_n = 1'b1;
    goto_slot(5'd12);
    check_eq("r_discard_pend", 32'(pending), 32'(0));
    check_eq("r_discard_rd", 32'(rd_data), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
